label_resolver: RTL

Second-pass partner to the connected-components labeler: it reads back the label equivalences that the labeler produces and turns provisional labels into final component labels.
- During a frame it accepts new-label registrations and merge pairs {max, min}, and keeps a union-find style equivalence table.
- At frame end it flattens the table so every entry points directly at its root.
- It then serves single-cycle-registered lookups from provisional label to resolved label for the relabel/output pass.

---
 rtl/label_resolver.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/label_resolver.sv
// Union-find label equivalence table: records merges during a frame, flattens at frame end, then serves
// registered lookups. Optional root counting is enabled with the RESOLVER_STATS_EN macro.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module label_resolver #(
    parameter int WIDTH = `WORD_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_label_valid,
    input  logic [WIDTH-1:0] new_label,
    input  logic             merge_valid,
    output logic             merge_ready,
    input  logic [WIDTH-1:0] merge_max,
    input  logic [WIDTH-1:0] merge_min,
    input  logic             frame_done,
    input  logic             clear,
    output logic             busy,
    output logic             ready,
    input  logic             lookup_valid,
    input  logic [WIDTH-1:0] lookup_label,
    output logic             q_valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] num_components
);
    localparam int DEPTH = 1 << WIDTH;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_LABEL = '1;

    typedef enum logic [2:0] {IDLE, CHASE_A, CHASE_B, LINK, FLATTEN, READY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, i_q, i_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             fd_pend_q, fd_pend_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic [WIDTH-1:0] tbl [DEPTH];
    logic             tbl_we;
    logic [WIDTH-1:0] tbl_wa, tbl_wd;
    logic             clr, nl_ok;

    assign clr   = reset | clear;
    assign nl_ok = new_label_valid && (state_q != FLATTEN) && (state_q != READY) && !clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= ONE;
            fd_pend_q <= 1'b0;
            q_valid_q <= 1'b0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            fd_pend_q <= fd_pend_d;
            q_valid_q <= q_valid_d;
            q_q       <= q_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        i_q <= i_d;
        if (tbl_we) tbl[tbl_wa] <= tbl_wd;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (frame_done || fd_pend_q) state_d = FLATTEN;
                         else if (merge_valid) state_d = CHASE_A;
                CHASE_A: if (tbl[a_q] == a_q) state_d = CHASE_B;
                CHASE_B: if (tbl[b_q] == b_q) state_d = LINK;
                // A colliding new label owns the write port, so the link waits
                LINK:    if (!new_label_valid) state_d = IDLE;
                FLATTEN: if (i_q == count_q || i_q + ONE == count_q) state_d = READY;
                READY:   state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    assign merge_ready = (state_q == IDLE) && !fd_pend_q && !frame_done;
    assign busy        = (state_q != IDLE) && (state_q != READY);
    assign ready       = (state_q == READY);
    assign q_valid     = q_valid_q;
    assign q           = q_q;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        count_d   = count_q;
        fd_pend_d = fd_pend_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        tbl_we    = 1'b0;
        tbl_wa    = new_label;
        tbl_wd    = new_label;
        if (clr) begin
            count_d   = ONE;
            fd_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_d       = ONE;
                    fd_pend_d = 1'b0;
                    if (merge_valid && merge_ready) begin
                        a_d = merge_max;
                        b_d = merge_min;
                    end
                end
                CHASE_A: begin
                    if (tbl[a_q] != a_q) a_d = tbl[a_q];
                    if (frame_done) fd_pend_d = 1'b1;
                end
                CHASE_B: begin
                    if (tbl[b_q] != b_q) b_d = tbl[b_q];
                    if (frame_done) fd_pend_d = 1'b1;
                end
                LINK: begin
                    if (frame_done) fd_pend_d = 1'b1;
                    if (!new_label_valid && a_q != b_q) begin
                        tbl_we = 1'b1;
                        tbl_wa = (a_q > b_q) ? a_q : b_q;
                        tbl_wd = (a_q > b_q) ? b_q : a_q;
                    end
                end
                FLATTEN: begin
                    // Lower entries are already flat, so one extra hop reaches the root
                    if (i_q != count_q) begin
                        tbl_we = 1'b1;
                        tbl_wa = i_q;
                        tbl_wd = tbl[tbl[i_q]];
                        i_d    = i_q + ONE;
                    end
                end
                READY: begin
                    if (lookup_valid) begin
                        q_valid_d = 1'b1;
                        if (lookup_label == '0)          q_d = '0;
                        else if (lookup_label >= count_q) q_d = lookup_label;
                        else                              q_d = tbl[lookup_label];
                    end
                end
                default: ;
            endcase
            if (nl_ok) begin
                tbl_we  = 1'b1;
                tbl_wa  = new_label;
                tbl_wd  = new_label;
                count_d = (new_label == MAX_LABEL) ? MAX_LABEL : new_label + ONE;
            end
        end
    end

`ifdef RESOLVER_STATS_EN
    logic [WIDTH-1:0] nc_q, nc_d;

    always_comb begin
        nc_d = nc_q;
        if (clr) nc_d = '0;
        else if (state_q == FLATTEN && i_q != count_q && tbl[i_q] == i_q) nc_d = nc_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) nc_q <= '0;
        else       nc_q <= nc_d;
    end

    assign num_components = nc_q;
`else
    assign num_components = '0;
`endif

endmodule
